conv_layer_sequencer: RTL
=========================

# conv_layer_sequencer

Top-level controller for one convolution layer pass on the IFM/weight BRAM + address generator + PE cluster datapath. It sequences host loading of the IFM BRAM and then the 16 weight BRAMs through a valid/ready stream, drives the shared write address and write enables, and raises the compute-start level to the address generator. It then counts `done_window` pulses until the configured number of output windows is produced, drains the PE pipeline, and signals completion.

## Interface
Parameters:
- `CNT_W`, 16: width of word/window counters and configuration fields.
- `DRAIN_CYC`, 2: cycles spent in DRAIN after the last window (PE cluster output latency), must be ≥1.
- `TO_W`, 12: watchdog counter width (used only with `CONV_SEQ_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a layer pass; honoured only in IDLE.
- `abort`  in  1  return to IDLE on the next edge from any state.
- `cfg_ifm_words`  in  CNT_W  number of 32-bit IFM words to load; latched on accepted `start`.
- `cfg_w_words`  in  CNT_W  words per weight BRAM; latched on accepted `start`.
- `cfg_windows`  in  CNT_W  output windows expected (OFM_W×OFM_W); latched on accepted `start`.
- `ld_valid`  in  1  host load beat valid (data goes directly to BRAM data inputs).
- `ld_ready`  out  1  sequencer accepts a beat this cycle.
- `addr`  out  32  shared BRAM write address (zero-extended word index).
- `wr_rd_en_IFM`  out  1  1 = write IFM BRAM this cycle.
- `wr_rd_en_Weight`  out  1  1 = write all weight BRAMs this cycle.
- `cal_start`  out  1  compute enable to address generator, held high through COMPUTE.
- `done_window`  in  1  one-cycle pulse from address generator per finished window.
- `win_valid`  out  16  per-PE valid; all bits = registered `done_window` during COMPUTE.
- `win_count`  out  CNT_W  windows completed in the current pass.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the pass completes.
- `error`  out  1  watchdog expired (sticky until next accepted `start` or reset).

## Operation
- States: IDLE, LOAD_IFM, LOAD_W, COMPUTE, DRAIN, FIN.
- IDLE: `ld_ready`=0, enables 0, `cal_start`=0. `start` → latch config, clear `win_count`, `addr`=0, `error`=0; next state LOAD_IFM, or LOAD_W if `cfg_ifm_words`=0, or COMPUTE if both word counts are 0.
- LOAD_IFM: `ld_ready`=1; beat = `ld_valid`&`ld_ready`; `wr_rd_en_IFM` = beat (combinational, same cycle as data). Each beat increments `addr`. On the beat with `addr`=`cfg_ifm_words`−1 → LOAD_W, `addr`←0 (LOAD_W skipped to COMPUTE if `cfg_w_words`=0).
- LOAD_W: identical handshake using `wr_rd_en_Weight`; last beat → COMPUTE, `addr`←0.
- COMPUTE: `cal_start`=1, `ld_ready`=0. Each `done_window` increments `win_count` (saturating at all-ones). When the increment reaches `cfg_windows` → DRAIN. If `cfg_windows`=0 → DRAIN immediately after one COMPUTE cycle.
- DRAIN: `cal_start`=0; counts `DRAIN_CYC` cycles → FIN.
- FIN: `done`=1 for one cycle → IDLE.
- `done_window` outside COMPUTE is ignored (no count, no `win_valid`).
- `start` while `busy` is ignored. `abort` has priority over every transition; `start`+`abort` in IDLE: abort wins, stays IDLE.

## Timing
- Reset values: state IDLE, `addr`=0, `ld_ready`=0, both enables 0, `cal_start`=0, `win_valid`=0, `win_count`=0, `busy`=0, `done`=0, `error`=0.
- `start` → `ld_ready` high on the next cycle (1-cycle latency).
- Write enable and `addr` valid in the same cycle as the accepted beat; `addr` advances on the following edge; no bubbles between back-to-back beats.
- `done_window` at cycle t → `win_valid`=16'hFFFF at t+1, `win_count` updated at t+1.
- Final window at t → DRAIN from t+1, `cal_start` low at t+1, `done` at t+1+`DRAIN_CYC`.
- Reset or `abort` mid-operation: all outputs return to reset values on the next edge (except `error` unaffected by `abort`).

## Configuration
- `CONV_SEQ_TIMEOUT_EN` defined: a TO_W-bit counter runs in COMPUTE, cleared by each `done_window`; reaching all-ones sets `error`=1 and forces IDLE (no `done`).
- Not defined: no watchdog; `error` tied to 0; COMPUTE waits indefinitely.

## Test plan
- Reset then `start` with ifm=4, w=3, windows=2, `ld_valid` always 1 → IFM writes at addr 0..3, weight writes 0..2, `cal_start` rises next cycle, two `done_window` → `win_count`=2, `done` pulse 2+`DRAIN_CYC` cycles later.
- `ld_valid` toggling 1,0,1,0 in LOAD_IFM → writes only on valid cycles, `addr` holds during gaps, final addr 3.
- ifm=0, w=0, windows=1 → IDLE→COMPUTE directly, no write enables ever asserted.
- `abort` in LOAD_W at addr 1 → next cycle IDLE, `busy`=0, `addr`=0; `done_window` pulses afterwards don't change `win_count`.
- `start` pulsed in COMPUTE with different cfg → ignored; pass finishes with original `cfg_windows`.
- With `CONV_SEQ_TIMEOUT_EN`, TO_W=4, no `done_window` → `error`=1 after 15 COMPUTE cycles, state IDLE, `done` never asserted.

Source files
------------

// File: rtl/conv_layer_sequencer.sv
`default_nettype none
// ============================================================================
// conv_layer_sequencer : IFM/weight BRAM load, compute and drain controller.
// Optional watchdog build macro: CONV_SEQ_TIMEOUT_EN.  Rev 1.0
// ============================================================================
module conv_layer_sequencer #(
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 2,
  parameter int TO_W      = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_ifm_words,
  input  logic [CNT_W-1:0] cfg_w_words,
  input  logic [CNT_W-1:0] cfg_windows,
  input  logic             ld_valid,
  output logic             ld_ready,
  output logic [31:0]      addr,
  output logic             wr_rd_en_IFM,
  output logic             wr_rd_en_Weight,
  output logic             cal_start,
  input  logic             done_window,
  output logic [15:0]      win_valid,
  output logic [CNT_W-1:0] win_count,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_IFM = 3'd1,
    S_LOAD_W   = 3'd2,
    S_COMPUTE  = 3'd3,
    S_DRAIN    = 3'd4,
    S_FIN      = 3'd5
  } state_t;

  localparam int c_drn_w = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [c_drn_w-1:0] c_drn_last = c_drn_w'(DRAIN_CYC - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_addr;
  logic [CNT_W-1:0]   r_cfg_ifm;
  logic [CNT_W-1:0]   r_cfg_w;
  logic [CNT_W-1:0]   r_cfg_win;
  logic [CNT_W-1:0]   r_win_count;
  logic               r_wv;
  logic [c_drn_w-1:0] r_drain_cnt;
  logic               w_last_ifm;
  logic               w_last_w;
  logic [CNT_W-1:0]   w_win_inc;
  logic               w_to_expire;

  assign w_last_ifm = (r_addr == r_cfg_ifm - 1'b1);
  assign w_last_w   = (r_addr == r_cfg_w - 1'b1);
  assign w_win_inc  = (r_win_count == {CNT_W{1'b1}}) ? r_win_count : r_win_count + 1'b1;

  assign ld_ready        = (r_state == S_LOAD_IFM) || (r_state == S_LOAD_W);
  assign wr_rd_en_IFM    = (r_state == S_LOAD_IFM) && ld_valid;
  assign wr_rd_en_Weight = (r_state == S_LOAD_W) && ld_valid;
  assign addr            = 32'(r_addr);
  assign cal_start       = (r_state == S_COMPUTE);
  assign win_valid       = {16{r_wv}};
  assign win_count       = r_win_count;
  assign busy            = (r_state != S_IDLE);
  assign done            = (r_state == S_FIN);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (cfg_ifm_words != '0)    w_next_state = S_LOAD_IFM;
          else if (cfg_w_words != '0) w_next_state = S_LOAD_W;
          else                        w_next_state = S_COMPUTE;
        end
      end
      S_LOAD_IFM: begin
        if (ld_valid && w_last_ifm)
          w_next_state = (r_cfg_w != '0) ? S_LOAD_W : S_COMPUTE;
      end
      S_LOAD_W: begin
        if (ld_valid && w_last_w) w_next_state = S_COMPUTE;
      end
      S_COMPUTE: begin
        if ((r_cfg_win == '0) || (done_window && (w_win_inc == r_cfg_win)))
          w_next_state = S_DRAIN;
        else if (w_to_expire)
          w_next_state = S_IDLE;
      end
      S_DRAIN: begin
        if (r_drain_cnt == c_drn_last) w_next_state = S_FIN;
      end
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    // abort outranks every transition, including start in IDLE
    if (abort) w_next_state = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_cfg_ifm   <= '0;
      r_cfg_w     <= '0;
      r_cfg_win   <= '0;
      r_win_count <= '0;
      r_wv        <= 1'b0;
      r_drain_cnt <= '0;
    end else if (abort) begin
      r_addr      <= '0;
      r_win_count <= '0;
      r_wv        <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_wv <= (r_state == S_COMPUTE) && done_window;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cfg_ifm   <= cfg_ifm_words;
            r_cfg_w     <= cfg_w_words;
            r_cfg_win   <= cfg_windows;
            r_addr      <= '0;
            r_win_count <= '0;
          end
        end
        S_LOAD_IFM: if (ld_valid) r_addr <= w_last_ifm ? '0 : r_addr + 1'b1;
        S_LOAD_W:   if (ld_valid) r_addr <= w_last_w ? '0 : r_addr + 1'b1;
        S_COMPUTE: begin
          r_drain_cnt <= '0;
          if (done_window) r_win_count <= w_win_inc;
        end
        S_DRAIN: r_drain_cnt <= r_drain_cnt + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam logic [TO_W-1:0] c_to_last = {{(TO_W-1){1'b1}}, 1'b0};

  logic [TO_W-1:0] r_to_cnt;
  logic            r_error;

  // the counter would reach all-ones on this edge
  assign w_to_expire = (r_state == S_COMPUTE) && !done_window && (r_to_cnt == c_to_last);
  assign error       = r_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt <= '0;
      r_error  <= 1'b0;
    end else begin
      if ((r_state != S_COMPUTE) || done_window || abort) r_to_cnt <= '0;
      else                                                r_to_cnt <= r_to_cnt + 1'b1;
      if (w_to_expire && !abort)                        r_error <= 1'b1;
      else if ((r_state == S_IDLE) && start && !abort)  r_error <= 1'b0;
    end
  end
`else
  assign w_to_expire = 1'b0;
  // no watchdog in this build, so the error flag is constant low
  assign error       = (TO_W < 0);
`endif

endmodule
`default_nettype wire
